// File: rtl/analog_pkg.sv
// Shared definitions for the analog scan sequencer: FSM states, config-word
// field positions and the result code written when a conversion times out.
`timescale 1ns/1ps
package analog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_MUX      = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_CONV     = 3'd4,
        ST_WAIT_EOC = 3'd5,
        ST_READ     = 3'd6,
        ST_STORE    = 3'd7
    } scan_state_e;

    localparam int CFG_EN_BIT     = 31;
    localparam int CFG_CHIP_MSB   = 29;
    localparam int CFG_CHIP_LSB   = 28;
    localparam int CFG_ADDR_MSB   = 27;
    localparam int CFG_ADDR_LSB   = 24;
    localparam int CFG_SETTLE_MSB = 23;
    localparam int CFG_SETTLE_LSB = 16;

    localparam logic [13:0] TIMEOUT_CODE = 14'h3FFF;

    // Active-low one-hot chip select for a 2-bit ADG chip number.
    function automatic logic [3:0] adg_chip_select(input logic [1:0] chip);
        return ~(4'b0001 << chip);
    endfunction

endpackage

// File: rtl/analog_cycle_timer.sv
// Loadable down-counter; done is high during the last cycle of a loaded
// interval, so a load of N keeps the caller in its state for N cycles.
`timescale 1ns/1ps
module analog_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_r;

    // Count down from the loaded value, parking at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/analog_scan_sequencer.sv
// Scans CH_NUM analog channels: fetches each channel's config word, routes the
// ADG multiplexer, runs one ADC conversion and writes the result out.
`timescale 1ns/1ps
module analog_scan_sequencer
    import analog_pkg::*;
#(
    parameter int CH_NUM      = 32,
    parameter int CONVST_W    = 2,
    parameter int RD_W        = 2,
    parameter int EOC_TIMEOUT = 255
) (
    input  logic        CLOCK_BMQ,
    input  logic        RST_N,
    input  logic        RUN,
    output logic [4:0]  ID_Convst_Analog,
    input  logic [31:0] Configer_Word,
    output logic [3:0]  CS_ADG,
    output logic [3:0]  ADD_ADG,
    output logic        CONVST_ADC,
    input  logic        EOC_ADC,
    output logic        CS_ADC,
    output logic        RD_ADC,
    input  logic [13:0] DATA_ADC,
    output logic        WR_EN,
    output logic [4:0]  WR_ADDR,
    output logic [13:0] WR_DATA,
    output logic        TIMEOUT_ERR
);

    scan_state_e state_r;
    logic [4:0]  idx_r;
    logic        fetch_ph_r;
    logic [1:0]  chip_r;
    logic [3:0]  addr_r;
    logic [7:0]  settle_r;
    logic [4:0]  next_idx_s;
    logic        timer_load_s;
    logic [7:0]  timer_val_s;
    logic        timer_done_s;

    assign ID_Convst_Analog = idx_r;

    analog_cycle_timer #(.W(8)) u_timer (
        .clk      (CLOCK_BMQ),
        .rst_n    (RST_N),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .done     (timer_done_s)
    );

    // Channel index successor with wrap at the last channel.
    always_comb begin
        next_idx_s = 5'd0;
        if (idx_r == 5'(CH_NUM - 1)) begin
            next_idx_s = 5'd0;
        end else begin
            next_idx_s = idx_r + 5'd1;
        end
    end

    // Timer loads coincide with the edge that enters the timed state.
    always_comb begin
        timer_load_s = 1'b0;
        timer_val_s  = 8'd0;
        case (state_r)
            ST_MUX: begin
                timer_load_s = 1'b1;
                if (settle_r == 8'd0) begin
                    timer_val_s = 8'd1;
                end else begin
                    timer_val_s = settle_r;
                end
            end
            ST_SETTLE: begin
                if (timer_done_s) begin
                    timer_load_s = 1'b1;
                    timer_val_s  = 8'(CONVST_W);
                end else begin
                    timer_load_s = 1'b0;
                end
            end
            ST_CONV: begin
                if (timer_done_s) begin
                    timer_load_s = 1'b1;
                    timer_val_s  = 8'(EOC_TIMEOUT);
                end else begin
                    timer_load_s = 1'b0;
                end
            end
            ST_WAIT_EOC: begin
                if (!EOC_ADC) begin
                    timer_load_s = 1'b1;
                    timer_val_s  = 8'(RD_W);
                end else begin
                    timer_load_s = 1'b0;
                end
            end
            default: begin
                timer_load_s = 1'b0;
                timer_val_s  = 8'd0;
            end
        endcase
    end

    // Scan FSM with all interface outputs registered.
    always_ff @(posedge CLOCK_BMQ) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            idx_r       <= 5'd0;
            fetch_ph_r  <= 1'b0;
            chip_r      <= 2'd0;
            addr_r      <= 4'd0;
            settle_r    <= 8'd0;
            CS_ADG      <= 4'hF;
            ADD_ADG     <= 4'd0;
            CONVST_ADC  <= 1'b1;
            CS_ADC      <= 1'b1;
            RD_ADC      <= 1'b1;
            WR_EN       <= 1'b0;
            WR_ADDR     <= 5'd0;
            WR_DATA     <= 14'd0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            WR_EN <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    CS_ADG     <= 4'hF;
                    ADD_ADG    <= 4'd0;
                    CONVST_ADC <= 1'b1;
                    CS_ADC     <= 1'b1;
                    RD_ADC     <= 1'b1;
                    fetch_ph_r <= 1'b0;
                    if (RUN) begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!fetch_ph_r) begin
                        fetch_ph_r <= 1'b1;
                    end else begin
                        fetch_ph_r <= 1'b0;
                        chip_r     <= Configer_Word[CFG_CHIP_MSB:CFG_CHIP_LSB];
                        addr_r     <= Configer_Word[CFG_ADDR_MSB:CFG_ADDR_LSB];
                        settle_r   <= Configer_Word[CFG_SETTLE_MSB:CFG_SETTLE_LSB];
                        if (Configer_Word[CFG_EN_BIT]) begin
                            state_r <= ST_MUX;
                        end else begin
                            // Disabled channel: leave the mux untouched and move on.
                            idx_r <= next_idx_s;
                            if (RUN) begin
                                state_r <= ST_FETCH;
                            end else begin
                                state_r <= ST_IDLE;
                                CS_ADG  <= 4'hF;
                                ADD_ADG <= 4'd0;
                            end
                        end
                    end
                end
                ST_MUX: begin
                    CS_ADG  <= adg_chip_select(chip_r);
                    ADD_ADG <= addr_r;
                    state_r <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (timer_done_s) begin
                        CONVST_ADC <= 1'b0;
                        state_r    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (timer_done_s) begin
                        CONVST_ADC <= 1'b1;
                        state_r    <= ST_WAIT_EOC;
                    end
                end
                ST_WAIT_EOC: begin
                    if (!EOC_ADC) begin
                        CS_ADC  <= 1'b0;
                        RD_ADC  <= 1'b0;
                        state_r <= ST_READ;
                    end else if (timer_done_s) begin
                        TIMEOUT_ERR <= 1'b1;
                        WR_DATA     <= TIMEOUT_CODE;
                        WR_ADDR     <= idx_r;
                        WR_EN       <= 1'b1;
                        state_r     <= ST_STORE;
                    end
                end
                ST_READ: begin
                    if (timer_done_s) begin
                        CS_ADC  <= 1'b1;
                        RD_ADC  <= 1'b1;
                        WR_DATA <= DATA_ADC;
                        WR_ADDR <= idx_r;
                        WR_EN   <= 1'b1;
                        state_r <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    idx_r <= next_idx_s;
                    if (RUN) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_IDLE;
                        CS_ADG  <= 4'hF;
                        ADD_ADG <= 4'd0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_analog_scan_sequencer.sv
// Scoreboard bench: an ADC/config-ROM model queues the expected write for each
// conversion start and the write monitor checks it against the DUT output.
`timescale 1ns/1ps
module tb_analog_scan_sequencer;

    localparam int CH_NUM      = 32;
    localparam int CONVST_W    = 2;
    localparam int RD_W        = 2;
    localparam int EOC_TIMEOUT = 255;
    localparam int EOC_DELAY   = 10;

    logic        CLOCK_BMQ = 1'b0;
    logic        RST_N;
    logic        RUN;
    logic [4:0]  ID_Convst_Analog;
    logic [31:0] Configer_Word = 32'd0;
    logic [3:0]  CS_ADG;
    logic [3:0]  ADD_ADG;
    logic        CONVST_ADC;
    logic        EOC_ADC = 1'b1;
    logic        CS_ADC;
    logic        RD_ADC;
    logic [13:0] DATA_ADC = 14'd0;
    logic        WR_EN;
    logic [4:0]  WR_ADDR;
    logic [13:0] WR_DATA;
    logic        TIMEOUT_ERR;

    analog_scan_sequencer #(
        .CH_NUM(CH_NUM), .CONVST_W(CONVST_W), .RD_W(RD_W), .EOC_TIMEOUT(EOC_TIMEOUT)
    ) dut (
        .CLOCK_BMQ        (CLOCK_BMQ),
        .RST_N            (RST_N),
        .RUN              (RUN),
        .ID_Convst_Analog (ID_Convst_Analog),
        .Configer_Word    (Configer_Word),
        .CS_ADG           (CS_ADG),
        .ADD_ADG          (ADD_ADG),
        .CONVST_ADC       (CONVST_ADC),
        .EOC_ADC          (EOC_ADC),
        .CS_ADC           (CS_ADC),
        .RD_ADC           (RD_ADC),
        .DATA_ADC         (DATA_ADC),
        .WR_EN            (WR_EN),
        .WR_ADDR          (WR_ADDR),
        .WR_DATA          (WR_DATA),
        .TIMEOUT_ERR      (TIMEOUT_ERR)
    );

    always #125 CLOCK_BMQ = ~CLOCK_BMQ;

    typedef struct packed {
        logic [4:0]  addr;
        logic [13:0] data;
        logic        to;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] cfg_mem [CH_NUM];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_idx  = 0;
    int          wr_cnt   = 0;
    int          to_cnt   = 0;
    int          conv5_cnt = 0;
    int          hold_req = 0;
    int          hold_used = 0;
    int          low_cnt  = 0;
    int          eoc_cnt  = 0;
    int          since_rise = 0;
    int          last_wr_addr = 0;
    bit          busy = 1'b0;
    bit          hold_cur = 1'b0;
    bit          timeout_seen = 1'b0;
    logic        prev_convst = 1'b1;
    logic [13:0] adc_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_cfg(input bit en, input int chip, input int addr, input int settle);
        return {en, 1'b0, 2'(chip), 4'(addr), 8'(settle), 16'h0000};
    endfunction

    function automatic int next_en(input int from);
        int j;
        j = from;
        for (int k = 0; k < CH_NUM; k++) begin
            j = (j + 1) % CH_NUM;
            if (cfg_mem[j][31]) return j;
        end
        return from;
    endfunction

    // ADC model, config ROM and write scoreboard, all evaluated mid-cycle.
    always @(negedge CLOCK_BMQ) begin
        exp_t e;
        logic [3:0] cs_exp;
        Configer_Word = cfg_mem[ID_Convst_Analog];
        since_rise++;
        if (!RST_N) begin
            exp_q.delete();
            exp_idx      = next_en(CH_NUM - 1);
            busy         = 1'b0;
            EOC_ADC      = 1'b1;
            prev_convst  = 1'b1;
            timeout_seen = 1'b0;
        end else begin
            if (!CONVST_ADC && prev_convst) begin
                check_eq("conv_id", 32'(ID_Convst_Analog), 32'(exp_idx));
                if (ID_Convst_Analog == 5'd5) conv5_cnt++;
                hold_cur = (hold_used < hold_req);
                if (hold_cur) hold_used++;
                adc_data = 14'($urandom_range(0, 16382));
                DATA_ADC = adc_data;
                e.addr = 5'(exp_idx);
                e.data = hold_cur ? 14'h3FFF : adc_data;
                e.to   = hold_cur;
                exp_q.push_back(e);
                exp_idx = next_en(exp_idx);
                low_cnt = 1;
                eoc_cnt = 0;
                busy    = 1'b1;
            end else if (!CONVST_ADC) begin
                low_cnt++;
            end
            if (CONVST_ADC && !prev_convst) begin
                check_eq("convst_width", 32'(low_cnt), 32'(CONVST_W));
                since_rise = 0;
            end
            prev_convst = CONVST_ADC;
            if (busy) begin
                eoc_cnt++;
                if (eoc_cnt == EOC_DELAY && !hold_cur) EOC_ADC = 1'b0;
                if (!RD_ADC) begin
                    EOC_ADC = 1'b1;
                    busy    = 1'b0;
                end
            end
            if (WR_EN) begin
                wr_cnt++;
                check_eq("wr_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("wr_addr", 32'(WR_ADDR), 32'(e.addr));
                    check_eq("wr_data", 32'(WR_DATA), 32'(e.data));
                    cs_exp = ~(4'b0001 << cfg_mem[e.addr][29:28]);
                    check_eq("cs_adg", 32'(CS_ADG), 32'(cs_exp));
                    check_eq("add_adg", 32'(ADD_ADG), 32'(cfg_mem[e.addr][27:24]));
                    if (e.to) begin
                        timeout_seen = 1'b1;
                        to_cnt++;
                        check_eq("timeout_wait_len", 32'(since_rise), 32'(EOC_TIMEOUT));
                    end
                    check_eq("timeout_err", 32'(TIMEOUT_ERR), 32'(timeout_seen));
                    if (e.addr == 5'd7) begin
                        check_eq("ch7_cs_adg", 32'(CS_ADG), 32'(4'b1011));
                        check_eq("ch7_add_adg", 32'(ADD_ADG), 32'd9);
                    end
                end
                last_wr_addr = int'(WR_ADDR);
            end
        end
    end

    task automatic wait_wr(input string tag, input int target, input int budget);
        int n = 0;
        while (wr_cnt < target && n < budget) begin
            @(negedge CLOCK_BMQ);
            n++;
        end
        check_eq(tag, 32'(wr_cnt >= target), 32'd1);
    endtask

    task automatic wait_level(input string tag, input int which, input logic lvl, input int budget);
        int n = 0;
        logic v;
        v = (which == 0) ? CONVST_ADC : RD_ADC;
        while (v !== lvl && n < budget) begin
            @(negedge CLOCK_BMQ);
            v = (which == 0) ? CONVST_ADC : RD_ADC;
            n++;
        end
        check_eq(tag, 32'(v), 32'(lvl));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_id"},     32'(ID_Convst_Analog), 32'd0);
        check_eq({tag, "_cs_adg"}, 32'(CS_ADG), 32'hF);
        check_eq({tag, "_add"},    32'(ADD_ADG), 32'd0);
        check_eq({tag, "_convst"}, 32'(CONVST_ADC), 32'd1);
        check_eq({tag, "_cs_adc"}, 32'(CS_ADC), 32'd1);
        check_eq({tag, "_rd"},     32'(RD_ADC), 32'd1);
        check_eq({tag, "_wr_en"},  32'(WR_EN), 32'd0);
        check_eq({tag, "_wr_addr"},32'(WR_ADDR), 32'd0);
        check_eq({tag, "_wr_data"},32'(WR_DATA), 32'd0);
        check_eq({tag, "_to_err"}, 32'(TIMEOUT_ERR), 32'd0);
    endtask

    initial begin
        int base;
        int c5;
        int next_id;
        for (int i = 0; i < CH_NUM; i++) cfg_mem[i] = mk_cfg(1'b1, i % 4, i % 16, 3);
        cfg_mem[7] = mk_cfg(1'b1, 2, 9, 3);
        cfg_mem[3] = mk_cfg(1'b1, 1, 12, 0);
        RST_N = 1'b0;
        RUN   = 1'b0;
        repeat (3) @(posedge CLOCK_BMQ);
        @(negedge CLOCK_BMQ);
        check_reset_outputs("reset");

        // Full scan 0..31 plus the wrap back to channel 0.
        @(posedge CLOCK_BMQ); #1;
        RST_N = 1'b1;
        RUN   = 1'b1;
        wait_wr("wait_scan1", 33, 3000);

        // Disable channel 5 for the rest of the run.
        cfg_mem[5] = mk_cfg(1'b0, 0, 0, 3);
        c5 = conv5_cnt;
        wait_wr("wait_scan2", 70, 3000);
        check_eq("ch5_no_convst", 32'(conv5_cnt), 32'(c5));

        // One channel with EOC held high.
        check_eq("to_err_before", 32'(TIMEOUT_ERR), 32'd0);
        hold_req = 1;
        base = 0;
        while (to_cnt < 1 && base < 1500) begin
            @(negedge CLOCK_BMQ);
            base++;
        end
        check_eq("timeout_seen", 32'(to_cnt), 32'd1);
        check_eq("to_err_sticky", 32'(TIMEOUT_ERR), 32'd1);
        wait_wr("wait_after_to", wr_cnt + 3, 300);
        check_eq("to_err_still", 32'(TIMEOUT_ERR), 32'd1);

        // Drop RUN while waiting for EOC.
        wait_level("conv_low", 0, 1'b0, 200);
        wait_level("conv_high", 0, 1'b1, 20);
        @(posedge CLOCK_BMQ); #1;
        RUN  = 1'b0;
        base = wr_cnt;
        wait_wr("wait_stop_store", base + 1, 100);
        repeat (30) @(negedge CLOCK_BMQ);
        check_eq("stopped_no_wr", 32'(wr_cnt), 32'(base + 1));
        next_id = (last_wr_addr + 1) % CH_NUM;
        check_eq("idle_index", 32'(ID_Convst_Analog), 32'(next_id));
        check_eq("idle_cs_adg", 32'(CS_ADG), 32'hF);
        check_eq("idle_convst", 32'(CONVST_ADC), 32'd1);
        check_eq("idle_rd", 32'(RD_ADC), 32'd1);
        @(posedge CLOCK_BMQ); #1;
        RUN = 1'b1;
        wait_wr("wait_resume", wr_cnt + 3, 300);

        // Reset while the ADC is being read.
        wait_level("rd_low", 1, 1'b0, 200);
        @(posedge CLOCK_BMQ); #1;
        RST_N = 1'b0;
        @(posedge CLOCK_BMQ);
        @(negedge CLOCK_BMQ);
        check_reset_outputs("rst_read");
        @(posedge CLOCK_BMQ); #1;
        RST_N = 1'b1;
        base = wr_cnt;
        wait_wr("wait_after_rst", base + 2, 300);
        check_eq("after_rst_addr", 32'(last_wr_addr), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
